// File: rtl/conv_loop_sequencer.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : conv_loop_sequencer                                        |
// | Description : Runtime-configurable convolution loop-nest sequencer.      |
// |               Walks kh -> kw -> ic_tile -> oc_tile (outer to inner).     |
// |               Each iteration runs one weight-load phase of MAC_COL reads  |
// |               and then one IFMap stream phase of OH*OW reads. Both read  |
// |               streams use a valid/ready handshake.                       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   start_in             start pulse, honoured only in IDLE
//   cfg_*_in             loop bounds, stride and IFMap geometry (latched at start)
//   w_ready_in           weight SRAM accepts the current read
//   ifmap_ready_in       IFMap SRAM accepts the current read
//   w_prefetch_out       first cycle of each weight-load phase
//   w_addr_out/_read_en  weight read request
//   ifmap_start_out      first cycle of each stream phase
//   ifmap_addr_out/_en   IFMap read request
//   ofmap_acc_en_out     current pass accumulates into the OFMap
//   busy_out             sequencer not idle
//   cfg_err_out          illegal configuration, coincides with mac_done_out
//   mac_done_out         one-cycle completion pulse
// Optional build macro:
//   SEQ_PERF_CNT_EN      adds perf_cycles_out / perf_stall_out counters
//------------------------------------------------------------------------------
`default_nettype none

module conv_loop_sequencer #(
  parameter int MAC_ROW        = 16,
  parameter int MAC_COL        = 16,
  parameter int W_ADDR_BIT     = 11,
  parameter int IFMAP_ADDR_BIT = 9,
  parameter int CFG_BIT        = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start_in,
  input  logic [CFG_BIT-1:0]        cfg_oc_tiles_in,
  input  logic [CFG_BIT-1:0]        cfg_ic_tiles_in,
  input  logic [CFG_BIT-1:0]        cfg_kw_in,
  input  logic [CFG_BIT-1:0]        cfg_kh_in,
  input  logic [CFG_BIT-1:0]        cfg_ow_in,
  input  logic [CFG_BIT-1:0]        cfg_oh_in,
  input  logic [CFG_BIT-1:0]        cfg_iw_in,
  input  logic [CFG_BIT-1:0]        cfg_ih_in,
  input  logic [1:0]                cfg_stride_in,
  input  logic                      w_ready_in,
  input  logic                      ifmap_ready_in,
  output logic                      w_prefetch_out,
  output logic [W_ADDR_BIT-1:0]     w_addr_out,
  output logic                      w_read_en_out,
  output logic                      ifmap_start_out,
  output logic [IFMAP_ADDR_BIT-1:0] ifmap_addr_out,
  output logic                      ifmap_read_en_out,
  output logic                      ofmap_acc_en_out,
  output logic                      busy_out,
  output logic                      cfg_err_out,
`ifdef SEQ_PERF_CNT_EN
  output logic                      mac_done_out,
  output logic [31:0]               perf_cycles_out,
  output logic [31:0]               perf_stall_out
`else
  output logic                      mac_done_out
`endif
);

  // Address arithmetic is done at 32 bits and truncated, so both address
  // widths must be strictly narrower than 32.
  generate
    if (MAC_ROW < 1 || MAC_COL < 1 || W_ADDR_BIT >= 32 || IFMAP_ADDR_BIT >= 32 ||
        W_ADDR_BIT < 1 || IFMAP_ADDR_BIT < 1 || CFG_BIT < 1) begin : g_bad_params
      $error("conv_loop_sequencer: illegal parameter set");
    end
  endgenerate

  localparam int                 COL_W     = $clog2(MAC_COL + 1);
  localparam logic [COL_W-1:0]   COL_LAST  = COL_W'(MAC_COL - 1);
  localparam logic [COL_W-1:0]   COL_ONE   = COL_W'(1);
  localparam logic [CFG_BIT-1:0] CFG_ONE   = CFG_BIT'(1);
  localparam logic [31:0]        MAC_COL_W = 32'(MAC_COL);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WLOAD  = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Latched configuration
  logic [CFG_BIT-1:0] cfg_oct_q, cfg_oct_d;
  logic [CFG_BIT-1:0] cfg_ict_q, cfg_ict_d;
  logic [CFG_BIT-1:0] cfg_kw_q,  cfg_kw_d;
  logic [CFG_BIT-1:0] cfg_kh_q,  cfg_kh_d;
  logic [CFG_BIT-1:0] cfg_ow_q,  cfg_ow_d;
  logic [CFG_BIT-1:0] cfg_oh_q,  cfg_oh_d;
  logic [CFG_BIT-1:0] cfg_iw_q,  cfg_iw_d;
  logic [CFG_BIT-1:0] cfg_ih_q,  cfg_ih_d;
  logic [1:0]         cfg_s_q,   cfg_s_d;

  // Loop counters
  logic [CFG_BIT-1:0] kh_q, kh_d;
  logic [CFG_BIT-1:0] kw_q, kw_d;
  logic [CFG_BIT-1:0] ic_q, ic_d;
  logic [CFG_BIT-1:0] oc_q, oc_d;
  logic [CFG_BIT-1:0] oh_q, oh_d;
  logic [CFG_BIT-1:0] ow_q, ow_d;
  logic [COL_W-1:0]   col_q, col_d;

  // err_q qualifies the DONE cycle; first_q marks the first cycle of a phase
  // so the prefetch/start pulses do not repeat while the first read stalls.
  logic err_q, err_d;
  logic first_q, first_d;

  logic cfg_zero;
  logic col_last, ow_last, oh_last, oc_last, ic_last, kw_last, kh_last;
  logic final_iter;
  logic in_wload, in_stream;

  assign cfg_zero = (cfg_oc_tiles_in == '0) | (cfg_ic_tiles_in == '0) |
                    (cfg_kw_in == '0) | (cfg_kh_in == '0) |
                    (cfg_ow_in == '0) | (cfg_oh_in == '0) |
                    (cfg_iw_in == '0) | (cfg_ih_in == '0) |
                    (cfg_stride_in == 2'd0);

  assign col_last   = (col_q == COL_LAST);
  assign ow_last    = (ow_q == cfg_ow_q - CFG_ONE);
  assign oh_last    = (oh_q == cfg_oh_q - CFG_ONE);
  assign oc_last    = (oc_q == cfg_oct_q - CFG_ONE);
  assign ic_last    = (ic_q == cfg_ict_q - CFG_ONE);
  assign kw_last    = (kw_q == cfg_kw_q - CFG_ONE);
  assign kh_last    = (kh_q == cfg_kh_q - CFG_ONE);
  assign final_iter = oc_last & ic_last & kw_last & kh_last;

  assign in_wload  = (state_q == S_WLOAD);
  assign in_stream = (state_q == S_STREAM);

  // ---------------------------------------------------------------------------
  // State / counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cfg_oct_q <= '0;
      cfg_ict_q <= '0;
      cfg_kw_q  <= '0;
      cfg_kh_q  <= '0;
      cfg_ow_q  <= '0;
      cfg_oh_q  <= '0;
      cfg_iw_q  <= '0;
      cfg_ih_q  <= '0;
      cfg_s_q   <= '0;
      kh_q      <= '0;
      kw_q      <= '0;
      ic_q      <= '0;
      oc_q      <= '0;
      oh_q      <= '0;
      ow_q      <= '0;
      col_q     <= '0;
      err_q     <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_oct_q <= cfg_oct_d;
      cfg_ict_q <= cfg_ict_d;
      cfg_kw_q  <= cfg_kw_d;
      cfg_kh_q  <= cfg_kh_d;
      cfg_ow_q  <= cfg_ow_d;
      cfg_oh_q  <= cfg_oh_d;
      cfg_iw_q  <= cfg_iw_d;
      cfg_ih_q  <= cfg_ih_d;
      cfg_s_q   <= cfg_s_d;
      kh_q      <= kh_d;
      kw_q      <= kw_d;
      ic_q      <= ic_d;
      oc_q      <= oc_d;
      oh_q      <= oh_d;
      ow_q      <= ow_d;
      col_q     <= col_d;
      err_q     <= err_d;
      first_q   <= first_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cfg_oct_d = cfg_oct_q;
    cfg_ict_d = cfg_ict_q;
    cfg_kw_d  = cfg_kw_q;
    cfg_kh_d  = cfg_kh_q;
    cfg_ow_d  = cfg_ow_q;
    cfg_oh_d  = cfg_oh_q;
    cfg_iw_d  = cfg_iw_q;
    cfg_ih_d  = cfg_ih_q;
    cfg_s_d   = cfg_s_q;
    kh_d      = kh_q;
    kw_d      = kw_q;
    ic_d      = ic_q;
    oc_d      = oc_q;
    oh_d      = oh_q;
    ow_d      = ow_q;
    col_d     = col_q;
    err_d     = err_q;
    first_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_in) begin
          cfg_oct_d = cfg_oc_tiles_in;
          cfg_ict_d = cfg_ic_tiles_in;
          cfg_kw_d  = cfg_kw_in;
          cfg_kh_d  = cfg_kh_in;
          cfg_ow_d  = cfg_ow_in;
          cfg_oh_d  = cfg_oh_in;
          cfg_iw_d  = cfg_iw_in;
          cfg_ih_d  = cfg_ih_in;
          cfg_s_d   = cfg_stride_in;
          kh_d      = '0;
          kw_d      = '0;
          ic_d      = '0;
          oc_d      = '0;
          oh_d      = '0;
          ow_d      = '0;
          col_d     = '0;
          err_d     = cfg_zero;
          if (cfg_zero) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WLOAD;
            first_d = 1'b1;
          end
        end
      end

      S_WLOAD: begin
        if (w_ready_in) begin
          if (col_last) begin
            col_d   = '0;
            state_d = S_STREAM;
            first_d = 1'b1;
          end else begin
            col_d = col_q + COL_ONE;
          end
        end
      end

      S_STREAM: begin
        if (ifmap_ready_in) begin
          if (!ow_last) begin
            ow_d = ow_q + CFG_ONE;
          end else begin
            ow_d = '0;
            if (!oh_last) begin
              oh_d = oh_q + CFG_ONE;
            end else begin
              oh_d = '0;
              if (final_iter) begin
                state_d = S_DONE;
              end else begin
                state_d = S_WLOAD;
                first_d = 1'b1;
                // Odometer advance, oc_t innermost
                if (!oc_last) begin
                  oc_d = oc_q + CFG_ONE;
                end else begin
                  oc_d = '0;
                  if (!ic_last) begin
                    ic_d = ic_q + CFG_ONE;
                  end else begin
                    ic_d = '0;
                    if (!kw_last) begin
                      kw_d = kw_q + CFG_ONE;
                    end else begin
                      kw_d = '0;
                      kh_d = kh_q + CFG_ONE;
                    end
                  end
                end
              end
            end
          end
        end
      end

      S_DONE: begin
        // start_in is deliberately not looked at here
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Address generation (32-bit unsigned, truncated at the port)
  // ---------------------------------------------------------------------------
  logic [31:0] w_addr_full;
  logic [31:0] ifmap_addr_full;
  logic        unused_addr_hi;

  assign w_addr_full =
    ((((32'(kh_q) * 32'(cfg_kw_q)) + 32'(kw_q)) * 32'(cfg_ict_q) + 32'(ic_q))
      * 32'(cfg_oct_q) + 32'(oc_q)) * MAC_COL_W + 32'(col_q);

  assign ifmap_addr_full =
    32'(ic_q) * 32'(cfg_ih_q) * 32'(cfg_iw_q) +
    (32'(oh_q) * 32'(cfg_s_q) + 32'(kh_q)) * 32'(cfg_iw_q) +
    (32'(ow_q) * 32'(cfg_s_q) + 32'(kw_q));

  assign unused_addr_hi = ^{w_addr_full[31:W_ADDR_BIT], ifmap_addr_full[31:IFMAP_ADDR_BIT]};

  // ---------------------------------------------------------------------------
  // Outputs (decoded from registered state, so all are 0 in IDLE / reset)
  // ---------------------------------------------------------------------------
  assign busy_out          = (state_q != S_IDLE);
  assign w_read_en_out     = in_wload;
  assign w_prefetch_out    = in_wload & first_q;
  assign w_addr_out        = in_wload ? w_addr_full[W_ADDR_BIT-1:0] : '0;
  assign ifmap_read_en_out = in_stream;
  assign ifmap_start_out   = in_stream & first_q;
  assign ifmap_addr_out    = in_stream ? ifmap_addr_full[IFMAP_ADDR_BIT-1:0] : '0;
  assign ofmap_acc_en_out  = in_stream & ((kh_q | kw_q | ic_q) != '0);
  assign mac_done_out      = (state_q == S_DONE);
  assign cfg_err_out       = (state_q == S_DONE) & err_q;

`ifdef SEQ_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  logic [31:0] perf_cycles_q;
  logic [31:0] perf_stall_q;
  logic        stall_now;

  assign stall_now = (in_wload & ~w_ready_in) | (in_stream & ~ifmap_ready_in);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else if ((state_q == S_IDLE) && start_in) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (busy_out) begin
        perf_cycles_q <= perf_cycles_q + 32'd1;
      end
      if (stall_now) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_cycles_out = perf_cycles_q;
  assign perf_stall_out  = perf_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_conv_loop_sequencer.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : tb_conv_loop_sequencer                                     |
// | Description : Self-checking bench for conv_loop_sequencer (MAC_COL=4).   |
// |               Table of configurations with hand-computed expectations,   |
// |               plus hand-written reset and idle sequences.                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module tb_conv_loop_sequencer;

  localparam int MAC_COL = 4;
  localparam int WAB     = 11;
  localparam int IAB     = 9;
  localparam int CB      = 8;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           start_in = 1'b0;
  logic [CB-1:0]  cfg_oc_tiles_in = '0, cfg_ic_tiles_in = '0;
  logic [CB-1:0]  cfg_kw_in = '0, cfg_kh_in = '0, cfg_ow_in = '0, cfg_oh_in = '0;
  logic [CB-1:0]  cfg_iw_in = '0, cfg_ih_in = '0;
  logic [1:0]     cfg_stride_in = '0;
  logic           w_ready_in = 1'b1;
  logic           ifmap_ready_in = 1'b1;
  logic           w_prefetch_out, w_read_en_out, ifmap_start_out, ifmap_read_en_out;
  logic [WAB-1:0] w_addr_out;
  logic [IAB-1:0] ifmap_addr_out;
  logic           ofmap_acc_en_out, busy_out, cfg_err_out, mac_done_out;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0]    perf_cycles_out, perf_stall_out;
`endif

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  conv_loop_sequencer #(
    .MAC_ROW        (16),
    .MAC_COL        (MAC_COL),
    .W_ADDR_BIT     (WAB),
    .IFMAP_ADDR_BIT (IAB),
    .CFG_BIT        (CB)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .start_in          (start_in),
    .cfg_oc_tiles_in   (cfg_oc_tiles_in),
    .cfg_ic_tiles_in   (cfg_ic_tiles_in),
    .cfg_kw_in         (cfg_kw_in),
    .cfg_kh_in         (cfg_kh_in),
    .cfg_ow_in         (cfg_ow_in),
    .cfg_oh_in         (cfg_oh_in),
    .cfg_iw_in         (cfg_iw_in),
    .cfg_ih_in         (cfg_ih_in),
    .cfg_stride_in     (cfg_stride_in),
    .w_ready_in        (w_ready_in),
    .ifmap_ready_in    (ifmap_ready_in),
    .w_prefetch_out    (w_prefetch_out),
    .w_addr_out        (w_addr_out),
    .w_read_en_out     (w_read_en_out),
    .ifmap_start_out   (ifmap_start_out),
    .ifmap_addr_out    (ifmap_addr_out),
    .ifmap_read_en_out (ifmap_read_en_out),
    .ofmap_acc_en_out  (ofmap_acc_en_out),
    .busy_out          (busy_out),
    .cfg_err_out       (cfg_err_out),
`ifdef SEQ_PERF_CNT_EN
    .mac_done_out      (mac_done_out),
    .perf_cycles_out   (perf_cycles_out),
    .perf_stall_out    (perf_stall_out)
`else
    .mac_done_out      (mac_done_out)
`endif
  );

  // One record: configuration, ready-stall windows (cycle offsets after start),
  // and expected latency / error / read counts / contents of one chosen pass.
  typedef struct packed {
    logic [7:0]       oct, ict, kh, kw, oh, ow, ih, iw;
    logic [1:0]       s;
    logic [7:0]       w_st, w_len, i_st, i_len;
    logic [7:0]       lat;
    logic             err;
    logic [7:0]       nw, ni;
    logic [7:0]       pass;   // 8'hFF: no per-pass content check
    logic [3:0][10:0] ew;
    logic [3:0][8:0]  ei;
    logic             acc;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs[NVEC];

  function automatic vec_t mk(input int oct, input int ict, input int kh, input int kw,
                              input int oh, input int ow, input int ih, input int iw,
                              input int s, input int lat, input int err,
                              input int nw, input int ni);
    vec_t v;
    v      = '0;
    v.oct  = 8'(oct);  v.ict = 8'(ict);  v.kh = 8'(kh);  v.kw = 8'(kw);
    v.oh   = 8'(oh);   v.ow  = 8'(ow);   v.ih = 8'(ih);  v.iw = 8'(iw);
    v.s    = 2'(s);    v.lat = 8'(lat);  v.err = err[0];
    v.nw   = 8'(nw);   v.ni  = 8'(ni);   v.pass = 8'hFF;
    return v;
  endfunction

  function automatic vec_t with_pass(input vec_t vin, input int p, input int w0,
                                     input int i0, input int i1, input int i2,
                                     input int i3, input int acc);
    vec_t v;
    v       = vin;
    v.pass  = 8'(p);
    for (int j = 0; j < 4; j++) v.ew[j] = 11'(w0 + j);
    v.ei[0] = 9'(i0); v.ei[1] = 9'(i1); v.ei[2] = 9'(i2); v.ei[3] = 9'(i3);
    v.acc   = acc[0];
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int all_outs();
    return int'({w_prefetch_out, w_addr_out, w_read_en_out, ifmap_start_out,
                 ifmap_addr_out, ifmap_read_en_out, ofmap_acc_en_out, busy_out,
                 cfg_err_out, mac_done_out});
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    logic [10:0] wq[$];
    logic [8:0]  iq[$];
    logic        aq[$];
    int k, done_k, npf, nis, ovl, unst, bbad, abad, idx;
    logic pw_pend, pi_pend, err_seen;
    logic [10:0] pw;
    logic [8:0]  pi;
    done_k = -1; npf = 0; nis = 0; ovl = 0; unst = 0; bbad = 0; abad = 0;
    pw_pend = 1'b0; pi_pend = 1'b0; err_seen = 1'b0; pw = '0; pi = '0;

    @(negedge clk);
    cfg_oc_tiles_in = v.oct; cfg_ic_tiles_in = v.ict;
    cfg_kh_in = v.kh; cfg_kw_in = v.kw; cfg_oh_in = v.oh; cfg_ow_in = v.ow;
    cfg_ih_in = v.ih; cfg_iw_in = v.iw; cfg_stride_in = v.s;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    k = 1;
    while (k <= 200) begin
      w_ready_in     = !(k >= int'(v.w_st) && k < int'(v.w_st) + int'(v.w_len));
      ifmap_ready_in = !(k >= int'(v.i_st) && k < int'(v.i_st) + int'(v.i_len));
      if (w_read_en_out && ifmap_read_en_out) ovl++;
      if (pw_pend && (!w_read_en_out || w_addr_out !== pw)) unst++;
      if (pi_pend && (!ifmap_read_en_out || ifmap_addr_out !== pi)) unst++;
      pw_pend = w_read_en_out && !w_ready_in;      pw = w_addr_out;
      pi_pend = ifmap_read_en_out && !ifmap_ready_in; pi = ifmap_addr_out;
      if (w_read_en_out && w_ready_in) wq.push_back(w_addr_out);
      if (ifmap_read_en_out && ifmap_ready_in) begin
        iq.push_back(ifmap_addr_out);
        aq.push_back(ofmap_acc_en_out);
      end
      if (ofmap_acc_en_out && !ifmap_read_en_out) abad++;
      if (w_prefetch_out) begin npf++; if (!w_read_en_out) abad++; end
      if (ifmap_start_out) begin nis++; if (!ifmap_read_en_out) abad++; end
      if (cfg_err_out && !mac_done_out) abad++;
      if (!busy_out) bbad++;
      if (mac_done_out) begin
        done_k   = k;
        err_seen = cfg_err_out;
        break;
      end
      @(negedge clk);
      k++;
    end
    w_ready_in = 1'b1; ifmap_ready_in = 1'b1;
    // A start offered during DONE must be ignored
    if (done_k > 0) start_in = 1'b1;

    chk($sformatf("v%0d done latency", id), done_k, int'(v.lat));
    chk($sformatf("v%0d cfg_err", id), int'(err_seen), int'(v.err));
    chk($sformatf("v%0d weight reads", id), wq.size(), int'(v.nw));
    chk($sformatf("v%0d ifmap reads", id), iq.size(), int'(v.ni));
    chk($sformatf("v%0d prefetch pulses", id), npf, int'(v.nw) / MAC_COL);
    chk($sformatf("v%0d ifmap_start pulses", id), nis, int'(v.ni) / 4);
    chk($sformatf("v%0d read overlap", id), ovl, 0);
    chk($sformatf("v%0d unstable stalled read", id), unst, 0);
    chk($sformatf("v%0d busy drop", id), bbad, 0);
    chk($sformatf("v%0d stray pulse", id), abad, 0);
    if (v.pass != 8'hFF) begin
      for (int j = 0; j < 4; j++) begin
        idx = int'(v.pass) * 4 + j;
        chk($sformatf("v%0d w_addr[%0d]", id, idx),
            (idx < wq.size()) ? int'(wq[idx]) : -1, int'(v.ew[j]));
        chk($sformatf("v%0d ifmap_addr[%0d]", id, idx),
            (idx < iq.size()) ? int'(iq[idx]) : -1, int'(v.ei[j]));
        chk($sformatf("v%0d acc_en[%0d]", id, idx),
            (idx < aq.size()) ? int'(aq[idx]) : -1, int'(v.acc));
      end
    end

    @(negedge clk);
    chk($sformatf("v%0d idle after done", id), int'(busy_out), 0);
    chk($sformatf("v%0d done one cycle", id), int'(mac_done_out), 0);
`ifdef SEQ_PERF_CNT_EN
    chk($sformatf("v%0d perf_cycles", id), int'(perf_cycles_out), int'(v.lat));
    chk($sformatf("v%0d perf_stall", id), int'(perf_stall_out),
        int'(v.w_len) + int'(v.i_len));
`endif
    start_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int quiet;
    vec_t v;
    //                          oct ict kh kw oh ow ih iw s  lat err nw  ni
    vecs[0] = with_pass(mk(1, 1, 1, 1, 2, 2, 2, 2, 1,   9, 0,  4,  4), 0,  0, 0, 1, 2, 3, 0);
    vecs[1] = with_pass(mk(1, 1, 3, 3, 2, 2, 4, 4, 1,  73, 0, 36, 36), 5, 20, 6, 7, 10, 11, 1);
    vecs[2] = with_pass(mk(1, 1, 1, 1, 2, 2, 5, 5, 2,   9, 0,  4,  4), 0,  0, 0, 2, 10, 12, 0);
    vecs[3] = with_pass(mk(2, 2, 1, 1, 2, 2, 2, 2, 1,  33, 0, 16, 16), 3, 12, 4, 5, 6, 7, 1);
    vecs[4] = with_pass(mk(2, 2, 1, 1, 2, 2, 2, 2, 1,  33, 0, 16, 16), 1,  4, 0, 1, 2, 3, 0);
    vecs[5] = with_pass(mk(1, 1, 2, 1, 2, 2, 7, 7, 3,  17, 0,  8,  8), 1,  4, 7, 10, 28, 31, 1);
    vecs[6] = mk(1, 1, 1, 0, 2, 2, 2, 2, 1, 1, 1, 0, 0);   // kw = 0
    vecs[7] = mk(1, 1, 1, 1, 2, 2, 2, 2, 0, 1, 1, 0, 0);   // stride = 0
    v = vecs[0]; v.i_st = 8'd6; v.i_len = 8'd3; v.lat = 8'd12; vecs[8] = v;
    v = vecs[0]; v.w_st = 8'd2; v.w_len = 8'd2; v.lat = 8'd11; vecs[9] = v;

    // Reset state
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset outputs", all_outs(), 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle after reset", all_outs(), 0);

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

    // Reset in the middle of STREAM aborts without a done pulse
    @(negedge clk);
    cfg_oc_tiles_in = 8'd1; cfg_ic_tiles_in = 8'd1; cfg_kh_in = 8'd1; cfg_kw_in = 8'd1;
    cfg_oh_in = 8'd2; cfg_ow_in = 8'd2; cfg_ih_in = 8'd2; cfg_iw_in = 8'd2;
    cfg_stride_in = 2'd1;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid-stream ifmap_read_en", int'(ifmap_read_en_out), 1);
    chk("mid-stream ifmap_addr", int'(ifmap_addr_out), 1);
    rstn = 1'b0;
    #1;
    chk("async reset outputs", all_outs(), 0);
    @(negedge clk);
    rstn = 1'b1;
    quiet = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mac_done_out || busy_out) quiet++;
    end
    chk("no done/busy after abort", quiet, 0);
    run_vec(vecs[0], 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

`default_nettype wire
